athena_cfg_bank: RTL and testbench
==================================

ATHENA_CFG_BANK -- requirements
Module: athena_cfg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of configuration registers (1..16).
REQ-002 SHALL have parameter REG_WIDTH, default 16: bits per register (1..32).
REQ-003 SHALL have parameter APPLY_MODE, default athena::APPLY_FRAME: APPLY_FRAME defers the commit to apply_strobe; APPLY_IMMEDIATE applies on the commit write.
REQ-004 SHALL have parameter DEFAULTS, default athena::CFG_DEFAULTS: per-register reset values.
REQ-005 bridge.clk  input  1: the single clock; all logic on its rising edge.
REQ-006 reset  input  1: asynchronous, active-high.
REQ-007 bridge  bus_if  -: uses addr (word index), wr, wr_data, rd, rd_data.
REQ-008 apply_strobe  input  1: single-cycle frame-boundary pulse in the bridge.clk domain.
REQ-009 cfg_active  output  NUM_REGS x REG_WIDTH: applied register values seen by the core.
REQ-010 cfg_pending  output  1: a commit is waiting for apply_strobe.
REQ-011 cfg_changed  output  1: one-cycle pulse when cfg_active is updated.

Function
REQ-012 SHALL decode the address map as follows: addr 0..NUM_REGS-1 are shadow registers; addr NUM_REGS is CTRL; any other address is unmapped.
REQ-013 On wr to a shadow address, SHALL load wr_data[REG_WIDTH-1:0] into that shadow on the next edge and ignore the upper bits.
REQ-014 On wr to CTRL with wr_data[0]=1, SHALL issue a commit; wr_data[0]=0 SHALL have no effect.
REQ-015 Writes to unmapped addresses SHALL be ignored.
REQ-016 In APPLY_IMMEDIATE, a commit SHALL copy all shadows to cfg_active on the same edge, with cfg_changed high the following cycle; cfg_pending SHALL stay 0.
REQ-017 In APPLY_FRAME, a commit SHALL set cfg_pending on the next edge.
REQ-018 In APPLY_FRAME, apply_strobe while cfg_pending=1 SHALL copy all shadows to cfg_active, clear cfg_pending, and pulse cfg_changed the following cycle.
REQ-019 apply_strobe while cfg_pending=0 SHALL be ignored.
REQ-020 If a commit and apply_strobe coincide in APPLY_FRAME with cfg_pending=0, the commit SHALL set pending and the apply SHALL defer to the next strobe.
REQ-021 If a commit and apply_strobe coincide with cfg_pending=1, the apply SHALL occur and cfg_pending SHALL remain 1.
REQ-022 If a shadow write and an apply coincide, the apply SHALL copy the pre-write shadow value; the new value SHALL remain in the shadow.
REQ-023 Repeated commits while pending SHALL be idempotent, leaving cfg_pending=1.
REQ-024 Read latency SHALL be 1 cycle: rd at cycle N drives rd_data at N+1, held until the next rd.
REQ-025 A shadow read SHALL return the shadow zero-extended to 32 bits.
REQ-026 A CTRL read SHALL return {30'b0, cfg_changed_sticky, cfg_pending}; the sticky bit is set by every apply and cleared by the CTRL read.
REQ-027 An unmapped read SHALL return 0.
REQ-028 A simultaneous wr and rd to the same shadow SHALL return the old value.

Reset
REQ-029 On reset, shadows and cfg_active SHALL take DEFAULTS.
REQ-030 On reset, cfg_pending, cfg_changed, the sticky bit and rd_data SHALL be 0.
REQ-031 Reset asserted mid-pending SHALL discard the commit; no cfg_changed pulse SHALL follow deassertion.

Structure
REQ-032 Package athena SHALL hold apply_mode_t (APPLY_FRAME, APPLY_IMMEDIATE), CFG_DEFAULTS, and the CTRL bit positions.
REQ-033 The block SHALL contain one sub-module, athena_cfg_apply, which owns the pending, changed and sticky sequencing.
REQ-034 Register storage and address decode SHALL stay in the top level.

Verification
REQ-035 Defaults: release reset, then read addr 0 and CTRL -> DEFAULTS[0] and 0x0; cfg_active equals DEFAULTS.
REQ-036 Frame apply: write 0x1234 to addr 1, commit, then strobe 5 cycles later -> pending=1 until the strobe; cfg_active[1]=0x1234 after it; one cfg_changed pulse.
REQ-037 Coincidence: commit and apply_strobe in the same cycle with pending=0 -> no apply; pending=1; the next strobe applies.
REQ-038 Shadow/apply race: write 0xBEEF to addr 0 in the strobe cycle while pending -> cfg_active[0] holds the old value; shadow read returns 0xBEEF.
REQ-039 Unmapped access: write to addr NUM_REGS+3, then read it -> no state change; read returns 0.
REQ-040 Reset mid-pending: commit, assert reset, release, then strobe -> cfg_active=DEFAULTS; cfg_changed never pulses.

Source files
------------

// File: rtl/athena_pkg.sv
// Shared types and constants for the athena configuration bank.
// Holds the apply mode, per-register reset values, bus widths and CTRL bits.
package athena;

    typedef enum logic {
        APPLY_FRAME     = 1'b0,
        APPLY_IMMEDIATE = 1'b1
    } apply_mode_t;

    localparam int MAX_REGS = 16;
    localparam int BUS_AW   = 8;
    localparam int BUS_DW   = 32;

    // Write side of CTRL
    localparam int CTRL_COMMIT  = 0;
    // Read side of CTRL
    localparam int CTRL_PENDING = 0;
    localparam int CTRL_STICKY  = 1;

    // Entry 0 is the rightmost element
    localparam logic [MAX_REGS-1:0][31:0] CFG_DEFAULTS = {
        {12{32'h0000_0000}},
        32'h0000_3333,
        32'h0000_2222,
        32'h0000_1111,
        32'h0000_00A5
    };

endpackage

// File: rtl/athena_bus_if.sv
// Simple register bridge: word address, write strobe/data, read strobe/data.
// Ports: clk (the bank's only clock); modport slave for the register bank.
interface bus_if
    import athena::*;
(
    input logic clk
);
    logic [BUS_AW-1:0] addr;
    logic              wr;
    logic [BUS_DW-1:0] wr_data;
    logic              rd;
    logic [BUS_DW-1:0] rd_data;

    modport slave (
        input  clk,
        input  addr,
        input  wr,
        input  wr_data,
        input  rd,
        output rd_data
    );

    modport master (
        input  clk,
        output addr,
        output wr,
        output wr_data,
        output rd,
        input  rd_data
    );
endinterface

// File: rtl/athena_cfg_apply.sv
// Commit/apply sequencing: pending flag, changed pulse and sticky apply bit.
// Ports: clk, reset, commit, apply_strobe, sticky_clr in; apply, pending,
// changed, sticky out. apply is combinational and tells the bank to copy.
module athena_cfg_apply
    import athena::*;
#(
    parameter apply_mode_t APPLY_MODE = APPLY_FRAME
) (
    input  logic clk,
    input  logic reset,
    input  logic commit,
    input  logic apply_strobe,
    input  logic sticky_clr,
    output logic apply,
    output logic pending,
    output logic changed,
    output logic sticky
);

    // A strobe only applies a commit that was already pending, so a
    // commit landing on a strobe waits for the next frame boundary.
    always_comb begin
        apply = 1'b0;
        if (APPLY_MODE == APPLY_IMMEDIATE)
            apply = commit;
        else
            apply = apply_strobe && pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            changed <= 1'b0;
            sticky  <= 1'b0;
        end else begin
            if (APPLY_MODE == APPLY_FRAME) begin
                // New commit wins over the apply that clears it
                if (commit)
                    pending <= 1'b1;
                else if (apply)
                    pending <= 1'b0;
            end else begin
                pending <= 1'b0;
            end
            changed <= apply;
            // An apply racing a CTRL read must not be lost
            if (apply)
                sticky <= 1'b1;
            else if (sticky_clr)
                sticky <= 1'b0;
        end
    end

endmodule

// File: rtl/athena_cfg_bank.sv
// Shadowed configuration register bank with frame-synchronous apply.
// Ports: bridge (bus_if slave, carries clk), reset, apply_strobe in;
// cfg_active, cfg_pending, cfg_changed out.
module athena_cfg_bank
    import athena::*;
#(
    parameter int                            NUM_REGS   = 4,
    parameter int                            REG_WIDTH  = 16,
    parameter apply_mode_t                   APPLY_MODE = APPLY_FRAME,
    parameter logic [MAX_REGS-1:0][31:0]     DEFAULTS   = CFG_DEFAULTS
) (
    bus_if.slave                             bridge,
    input  logic                             reset,
    input  logic                             apply_strobe,
    output logic [NUM_REGS-1:0][REG_WIDTH-1:0] cfg_active,
    output logic                             cfg_pending,
    output logic                             cfg_changed
);

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] shadow;
    logic [NUM_REGS-1:0]                sh_sel;
    logic                               ctrl_sel;
    logic                               commit;
    logic                               apply;
    logic                               sticky;
    logic                               sticky_clr;
    logic [BUS_DW-1:0]                  rdata_nx;

    always_comb begin
        ctrl_sel = (bridge.addr == BUS_AW'(NUM_REGS));
        for (int i = 0; i < NUM_REGS; i++)
            sh_sel[i] = (bridge.addr == BUS_AW'(i));
    end

    assign commit     = bridge.wr && ctrl_sel && bridge.wr_data[CTRL_COMMIT];
    assign sticky_clr = bridge.rd && ctrl_sel;

    // Read mux; unmapped addresses fall through to zero
    always_comb begin
        rdata_nx = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (sh_sel[i])
                rdata_nx[REG_WIDTH-1:0] = shadow[i];
        if (ctrl_sel) begin
            rdata_nx[CTRL_PENDING] = cfg_pending;
            rdata_nx[CTRL_STICKY]  = sticky;
        end
    end

    // Nonblocking copy means an apply sees pre-write shadow values
    always_ff @(posedge bridge.clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i]     <= DEFAULTS[i][REG_WIDTH-1:0];
                cfg_active[i] <= DEFAULTS[i][REG_WIDTH-1:0];
            end
            bridge.rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (bridge.wr && sh_sel[i])
                    shadow[i] <= bridge.wr_data[REG_WIDTH-1:0];
            if (apply)
                cfg_active <= shadow;
            if (bridge.rd)
                bridge.rd_data <= rdata_nx;
        end
    end

    athena_cfg_apply #(
        .APPLY_MODE (APPLY_MODE)
    ) u_apply (
        .clk          (bridge.clk),
        .reset        (reset),
        .commit       (commit),
        .apply_strobe (apply_strobe),
        .sticky_clr   (sticky_clr),
        .apply        (apply),
        .pending      (cfg_pending),
        .changed      (cfg_changed),
        .sticky       (sticky)
    );

endmodule

// File: tb/tb_athena_cfg_bank.sv
// Directed self-checking bench for athena_cfg_bank (4 x 16, frame mode).
// Checks defaults, frame apply, coincidences, races, unmapped and reset.
module tb_athena_cfg_bank;

    logic             clk = 1'b0;
    logic             reset;
    logic             apply_strobe;
    logic [3:0][15:0] cfg_active;
    logic             cfg_pending;
    logic             cfg_changed;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_if bridge (.clk(clk));

    athena_cfg_bank dut (
        .bridge       (bridge),
        .reset        (reset),
        .apply_strobe (apply_strobe),
        .cfg_active   (cfg_active),
        .cfg_pending  (cfg_pending),
        .cfg_changed  (cfg_changed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        bridge.addr    = a;
        bridge.wr_data = d;
        bridge.wr      = 1'b1;
        tick();
        bridge.wr      = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a);
        bridge.addr = a;
        bridge.rd   = 1'b1;
        tick();
        bridge.rd   = 1'b0;
    endtask

    task automatic strobe();
        apply_strobe = 1'b1;
        tick();
        apply_strobe = 1'b0;
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_a0"}, 32'(cfg_active[0]), 32'h00A5);
        check({tag, "_a1"}, 32'(cfg_active[1]), 32'h1111);
        check({tag, "_a2"}, 32'(cfg_active[2]), 32'h2222);
        check({tag, "_a3"}, 32'(cfg_active[3]), 32'h3333);
    endtask

    initial begin
        reset          = 1'b1;
        apply_strobe   = 1'b0;
        bridge.addr    = '0;
        bridge.wr      = 1'b0;
        bridge.wr_data = '0;
        bridge.rd      = 1'b0;
        tick();
        tick();
        check("rst_pending", 32'(cfg_pending), 32'h0);
        check("rst_changed", 32'(cfg_changed), 32'h0);
        check("rst_rd_data", bridge.rd_data, 32'h0);
        reset = 1'b0;
        tick();

        // Defaults
        check_defaults("def");
        bus_rd(8'd0);
        check("def_rd0", bridge.rd_data, 32'h00A5);
        bus_rd(8'd4);
        check("def_ctrl", bridge.rd_data, 32'h0);

        // Frame apply, upper write bits dropped
        bus_wr(8'd1, 32'hFFFF_1234);
        bus_rd(8'd1);
        check("fa_shadow1", bridge.rd_data, 32'h1234);
        check("fa_act1_old", 32'(cfg_active[1]), 32'h1111);
        bus_wr(8'd4, 32'h1);
        check("fa_pend_set", 32'(cfg_pending), 32'h1);
        check("fa_chg_none", 32'(cfg_changed), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fa_wait_pend", 32'(cfg_pending), 32'h1);
            check("fa_wait_chg", 32'(cfg_changed), 32'h0);
        end
        strobe();
        check("fa_act1_new", 32'(cfg_active[1]), 32'h1234);
        check("fa_chg_pulse", 32'(cfg_changed), 32'h1);
        check("fa_pend_clr", 32'(cfg_pending), 32'h0);
        tick();
        check("fa_chg_once", 32'(cfg_changed), 32'h0);
        bus_rd(8'd4);
        check("fa_ctrl_sticky", bridge.rd_data, 32'h2);
        bus_rd(8'd4);
        check("fa_ctrl_clr", bridge.rd_data, 32'h0);

        // Commit coinciding with strobe while idle
        bus_wr(8'd2, 32'h5555);
        bridge.addr    = 8'd4;
        bridge.wr_data = 32'h1;
        bridge.wr      = 1'b1;
        apply_strobe   = 1'b1;
        tick();
        bridge.wr      = 1'b0;
        apply_strobe   = 1'b0;
        check("co_pend", 32'(cfg_pending), 32'h1);
        check("co_chg", 32'(cfg_changed), 32'h0);
        check("co_act2_old", 32'(cfg_active[2]), 32'h2222);
        strobe();
        check("co_act2_new", 32'(cfg_active[2]), 32'h5555);
        check("co_chg2", 32'(cfg_changed), 32'h1);
        check("co_pend2", 32'(cfg_pending), 32'h0);

        // Shadow write racing the apply
        bus_wr(8'd4, 32'h1);
        bridge.addr    = 8'd0;
        bridge.wr_data = 32'h0000_BEEF;
        bridge.wr      = 1'b1;
        apply_strobe   = 1'b1;
        tick();
        bridge.wr      = 1'b0;
        apply_strobe   = 1'b0;
        check("race_act0", 32'(cfg_active[0]), 32'h00A5);
        check("race_chg", 32'(cfg_changed), 32'h1);
        bus_rd(8'd0);
        check("race_shadow0", bridge.rd_data, 32'hBEEF);

        // Simultaneous write and read of one shadow
        bridge.addr    = 8'd3;
        bridge.wr_data = 32'h7777;
        bridge.wr      = 1'b1;
        bridge.rd      = 1'b1;
        tick();
        bridge.wr      = 1'b0;
        bridge.rd      = 1'b0;
        check("wr_rd_old", bridge.rd_data, 32'h3333);
        bus_rd(8'd3);
        check("wr_rd_new", bridge.rd_data, 32'h7777);

        // Commit coinciding with strobe while pending
        bus_wr(8'd4, 32'h1);
        bridge.addr    = 8'd4;
        bridge.wr_data = 32'h1;
        bridge.wr      = 1'b1;
        apply_strobe   = 1'b1;
        tick();
        bridge.wr      = 1'b0;
        apply_strobe   = 1'b0;
        check("cp_act3", 32'(cfg_active[3]), 32'h7777);
        check("cp_act0", 32'(cfg_active[0]), 32'hBEEF);
        check("cp_chg", 32'(cfg_changed), 32'h1);
        check("cp_pend", 32'(cfg_pending), 32'h1);
        strobe();
        check("cp_pend_clr", 32'(cfg_pending), 32'h0);
        check("cp_chg2", 32'(cfg_changed), 32'h1);
        tick();

        // Strobe with nothing pending
        strobe();
        check("idle_strobe_chg", 32'(cfg_changed), 32'h0);
        check("idle_strobe_pend", 32'(cfg_pending), 32'h0);
        check("rd_hold", bridge.rd_data, 32'h7777);
        bus_rd(8'd4);
        check("ctrl_sticky2", bridge.rd_data, 32'h2);

        // CTRL write with bit0 clear, then repeated commits
        bus_wr(8'd4, 32'hFFFF_FFFE);
        check("ctrl_nop", 32'(cfg_pending), 32'h0);
        bus_wr(8'd4, 32'h1);
        bus_wr(8'd4, 32'h1);
        check("rep_commit", 32'(cfg_pending), 32'h1);
        bus_rd(8'd4);
        check("rep_ctrl", bridge.rd_data, 32'h1);

        // Unmapped access
        bus_wr(8'd7, 32'hFFFF_FFFF);
        bus_rd(8'd7);
        check("unm_rd", bridge.rd_data, 32'h0);
        check("unm_act3", 32'(cfg_active[3]), 32'h7777);
        check("unm_pend", 32'(cfg_pending), 32'h1);
        bus_rd(8'd0);
        check("unm_shadow0", bridge.rd_data, 32'hBEEF);

        // Reset while pending
        reset = 1'b1;
        tick();
        check("mr_pend", 32'(cfg_pending), 32'h0);
        check("mr_rd_data", bridge.rd_data, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("mr_chg_rel", 32'(cfg_changed), 32'h0);
        strobe();
        check("mr_chg_strobe", 32'(cfg_changed), 32'h0);
        check("mr_pend2", 32'(cfg_pending), 32'h0);
        tick();
        check("mr_chg_after", 32'(cfg_changed), 32'h0);
        check_defaults("mr");
        bus_rd(8'd1);
        check("mr_shadow1", bridge.rd_data, 32'h1111);
        bus_rd(8'd4);
        check("mr_ctrl", bridge.rd_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
